// File: rtl/vram_write_arbiter.sv
// Single VRAM write-port arbiter: CPU character writes (via a small FIFO) versus the
// clear engine's write stream, with a burst limit that guarantees CPU forward progress.
module vram_write_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BURST  = 8,
    parameter int COLS       = 80,
    parameter int ROWS       = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_valid,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    output logic        cpu_ready,
    input  logic        clr_req,
    input  logic [15:0] clr_addr,
    input  logic [7:0]  clr_data,
    output logic        clr_gnt,
    input  logic        ovf_clr,
    output logic        overflow,
    output logic [7:0]  drop_cnt,
    output logic        busy,
    output logic [15:0] vram_write_address,
    output logic [7:0]  vram_write_data
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]   DEPTH_LIM = CNT_W'(FIFO_DEPTH);
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST);

    typedef enum logic [1:0] {SEL_IDLE, SEL_CLR, SEL_CPU} sel_t;

    logic [20:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [BURST_W-1:0] burst;
    logic [20:0]        head;
    logic               fifo_empty;
    logic               addr_write, in_range, accept, push, drop, lost, pop;
    sel_t               sel;
    logic               unused_bits;

    assign unused_bits = ^{cpu_addr[14:13], cpu_addr[7], clr_addr[15], head[15]};

    assign fifo_empty = (count == '0);
    assign cpu_ready  = (count < DEPTH_LIM);
    assign head       = mem[rd_ptr];

    // Addresses with bit15 set are accepted but are not writes, so they vanish silently.
    assign addr_write = ~cpu_addr[15];
    assign in_range   = (int'(cpu_addr[12:8]) < ROWS) && (int'(cpu_addr[6:0]) < COLS);
    assign accept     = cpu_valid & cpu_ready & addr_write;
    assign push       = accept & in_range;
    assign drop       = accept & ~in_range;
    assign lost       = cpu_valid & ~cpu_ready;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        sel = SEL_IDLE;
        if (clr_req && (fifo_empty || burst < BURST_LIM))
            sel = SEL_CLR;
        else if (!fifo_empty)
            sel = SEL_CPU;
    end

    assign pop     = (sel == SEL_CPU);
    assign clr_gnt = rst & (sel == SEL_CLR);
    assign busy    = rst & (~fifo_empty | clr_req);

    // NOTE: FIFO storage is not reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {cpu_addr[12:0], cpu_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            burst    <= '0;
            overflow <= 1'b0;
            drop_cnt <= 8'h00;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);

            if (sel == SEL_CLR && !fifo_empty)
                burst <= burst + BURST_W'(1);
            else
                burst <= '0;

            // A fresh loss wins over a simultaneous clear request.
            if (lost)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;

            if (drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vram_write_address <= 16'h8000;
            vram_write_data    <= 8'h00;
        end else begin
            case (sel)
                SEL_CLR: begin
                    vram_write_address <= {1'b0, clr_addr[14:0]};
                    vram_write_data    <= clr_data;
                end
                SEL_CPU: begin
                    vram_write_address <= {3'b000, head[20:16], 1'b0, head[14:8]};
                    vram_write_data    <= head[7:0];
                end
                default: vram_write_address <= 16'h8000;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Self-checking bench for vram_write_arbiter: directed scenarios plus random traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_vram_write_arbiter;

    localparam int FIFO_DEPTH = 4;
    localparam int MAX_BURST  = 8;
    localparam int COLS       = 80;
    localparam int ROWS       = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_valid = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_data = 8'h00;
    logic        cpu_ready;
    logic        clr_req = 1'b0;
    logic [15:0] clr_addr = 16'h0000;
    logic [7:0]  clr_data = 8'h00;
    logic        clr_gnt;
    logic        ovf_clr = 1'b0;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        busy;
    logic [15:0] vram_write_address;
    logic [7:0]  vram_write_data;

    always #5 clk = ~clk;

    vram_write_arbiter #(
        .FIFO_DEPTH(FIFO_DEPTH), .MAX_BURST(MAX_BURST), .COLS(COLS), .ROWS(ROWS)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ready(cpu_ready),
        .clr_req(clr_req), .clr_addr(clr_addr), .clr_data(clr_data), .clr_gnt(clr_gnt),
        .ovf_clr(ovf_clr), .overflow(overflow), .drop_cnt(drop_cnt), .busy(busy),
        .vram_write_address(vram_write_address), .vram_write_data(vram_write_data)
    );

    typedef struct {
        int row;
        int col;
        int data;
    } wr_t;

    wr_t q[$];
    int  m_burst;
    bit  m_ovf;
    int  m_drop;
    int  m_vaddr;
    int  m_vdata;
    bit  m_took_clr;
    int  n_checks = 0;
    int  n_errors = 0;
    logic last_gnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_burst    = 0;
        m_ovf      = 0;
        m_drop     = 0;
        m_vaddr    = 'h8000;
        m_vdata    = 0;
        m_took_clr = 0;
    endfunction

    // One clock cycle: check combinational outputs, advance the model at the edge,
    // then check registered outputs just after it.
    task automatic tick();
        bit  empty, ready, take_clr, take_cpu;
        wr_t e;
        int  row, col;
        #1;
        empty    = (q.size() == 0);
        ready    = (q.size() < FIFO_DEPTH);
        take_clr = clr_req && (empty || m_burst < MAX_BURST);
        take_cpu = !take_clr && !empty;
        check("cpu_ready", cpu_ready, ready);
        check("clr_gnt", clr_gnt, take_clr);
        check("busy", busy, !empty || clr_req);
        last_gnt = clr_gnt;
        @(posedge clk);
        if (take_clr) begin
            m_vaddr = clr_addr % 32768;
            m_vdata = clr_data;
            m_burst = empty ? 0 : m_burst + 1;
        end else if (take_cpu) begin
            e       = q.pop_front();
            m_vaddr = e.row * 256 + e.col;
            m_vdata = e.data;
            m_burst = 0;
        end else begin
            m_vaddr = 'h8000;
            m_burst = 0;
        end
        m_took_clr = take_clr;
        if (cpu_valid && !ready)
            m_ovf = 1;
        else if (ovf_clr)
            m_ovf = 0;
        if (cpu_valid && ready && cpu_addr < 32768) begin
            row = (cpu_addr / 256) % 32;
            col = cpu_addr % 128;
            if (row >= ROWS || col >= COLS) begin
                if (m_drop < 255) m_drop++;
            end else begin
                e.row  = row;
                e.col  = col;
                e.data = cpu_data;
                q.push_back(e);
            end
        end
        #1;
        check("vram_addr", vram_write_address, m_vaddr);
        check("vram_data", vram_write_data, m_vdata);
        check("overflow", overflow, m_ovf);
        check("drop_cnt", drop_cnt, m_drop);
    endtask

    // Asserts reset between edges and checks that outputs clear without waiting for a clock.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_ready", cpu_ready, 1);
        check("rst_gnt", clr_gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_vaddr", vram_write_address, 'h8000);
        check("rst_vdata", vram_write_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int run;
        int r;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Out-of-range and non-write CPU addresses.
        cpu_valid = 1; cpu_addr = 16'h1E00; cpu_data = 8'h11; tick();
        cpu_addr = 16'h0050; tick();
        cpu_addr = 16'h8123; tick();
        cpu_valid = 0; tick();
        check("oor_drop2", drop_cnt, 2);

        // Single CPU write and its two-cycle latency.
        cpu_valid = 1; cpu_addr = 16'h0203; cpu_data = 8'h41; tick();
        cpu_valid = 0; tick();
        check("single_addr", vram_write_address, 'h0203);
        tick();
        check("single_after", vram_write_address, 'h8000);

        // Fill and overflow while clears hold the port.
        clr_req = 1; clr_addr = 16'h1234; clr_data = 8'h20;
        for (int i = 0; i < 5; i++) begin
            cpu_valid = 1; cpu_addr = 16'((i + 1) * 256 + i + 2); cpu_data = 8'(8'h30 + i);
            tick();
        end
        cpu_valid = 0;
        check("fill_ovf", overflow, 1);
        ovf_clr = 1; tick();
        ovf_clr = 0;
        check("ovf_cleared", overflow, 0);
        clr_req = 0;
        for (int i = 0; i < 6; i++) tick();

        // Clear starvation guard: one queued CPU write versus a continuous clear stream.
        do_reset();
        clr_req = 1; clr_addr = 16'hC345; clr_data = 8'h7E;
        cpu_valid = 1; cpu_addr = 16'h0A05; cpu_data = 8'h5A; tick();
        cpu_valid = 0;
        run = 0;
        for (int i = 0; i < 20; i++) begin
            clr_data = 8'(8'h80 + i);
            tick();
            if (last_gnt !== 1'b1) break;
            run++;
        end
        check("starve_run", run, MAX_BURST);
        check("starve_cpu", vram_write_address, 'h0A05);
        tick();
        check("starve_resume", last_gnt, 1);
        clr_req = 0; tick();

        // Clear and CPU requests arriving together on an empty FIFO.
        clr_req = 1; clr_addr = 16'h0777; clr_data = 8'hAA;
        cpu_valid = 1; cpu_addr = 16'h0102; cpu_data = 8'h55; tick();
        clr_req = 0; cpu_valid = 0; tick();
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cpu_valid = ($urandom_range(0, 99) < 60);
            r = $urandom_range(0, 9);
            if (r == 0)
                cpu_addr = 16'($urandom);
            else if (r == 1)
                cpu_addr = 16'($urandom_range(ROWS, 31) * 256 + $urandom_range(0, 127));
            else
                cpu_addr = 16'($urandom_range(0, 3) * 8192 + $urandom_range(0, ROWS - 1) * 256
                               + $urandom_range(0, 1) * 128 + $urandom_range(0, COLS - 1));
            cpu_data = 8'($urandom);
            if (!clr_req || m_took_clr) begin
                clr_req  = ($urandom_range(0, 99) < 50);
                clr_addr = 16'($urandom);
                clr_data = 8'($urandom);
            end
            ovf_clr = ($urandom_range(0, 19) == 0);
            tick();
        end
        cpu_valid = 0; ovf_clr = 0;
        if (!clr_req || m_took_clr) clr_req = 0;
        for (int i = 0; i < 12; i++) begin
            if (m_took_clr) clr_req = 0;
            tick();
        end

        // Async reset with queued entries and a pending clear.
        clr_req = 1; clr_addr = 16'h0F0F; clr_data = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            cpu_valid = 1; cpu_addr = 16'(16'h0300 + i); cpu_data = 8'(8'h61 + i);
            tick();
        end
        cpu_valid = 0;
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        clr_req = 0;
        for (int i = 0; i < 4; i++) tick();

        // Drop counter saturation.
        cpu_valid = 1; cpu_addr = 16'h1F7F;
        for (int i = 0; i < 260; i++) tick();
        cpu_valid = 0; tick();
        check("drop_sat", drop_cnt, 255);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
